deck_dealer_ctrl: RTL and testbench

- Sequences the deck memory and shares it between the player-hand FSM and the dealer-hand FSM.
- Triggers the shuffle and waits for it to complete, arbitrates draw requests, and drives the read address and strobe.
- Decodes the raw card into a blackjack value and returns it to the winning requester.
- Reshuffles automatically when the deck is exhausted or a new round is requested.

---
 rtl/blackjack_pkg.sv | 14 +
 rtl/card_decoder.sv | 13 +
 rtl/deck_dealer_ctrl.sv | 104 ++++++++++
 tb/tb_deck_dealer_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/blackjack_pkg.sv
// blackjack_pkg: shared deck controller encodings, card word layout and blackjack values
package blackjack_pkg;
  localparam int DECK_SIZE = 52;
  localparam logic [3:0] ACE = 4'd1;
  localparam logic [3:0] FACE_MIN = 4'd11;
  localparam logic [3:0] RANK_MAX = 4'd13;
  localparam int RANK_LSB = 0;
  localparam int RANK_MSB = 3;
  localparam int SUIT_LSB = 4;
  localparam int SUIT_MSB = 5;
  localparam logic [4:0] VALUE_ACE = 5'd11;
  localparam logic [4:0] VALUE_FACE = 5'd10;
  typedef enum logic [2:0] {SHUF_REQ, SHUF_WAIT, READY, READ, WAIT, DONE} state_t;
endpackage

// File: rtl/card_decoder.sv
// card_decoder: raw rank to blackjack value, ace flag and out-of-range flag
module card_decoder
  import blackjack_pkg::*;
(
  input  logic [3:0] rank,
  output logic [4:0] value,
  output logic       is_ace,
  output logic       err
);
  assign is_ace = rank == ACE;
  assign err = rank == 4'd0 || rank > RANK_MAX;
  assign value = err ? 5'd0 : is_ace ? VALUE_ACE : rank >= FACE_MIN ? VALUE_FACE : {1'b0, rank};
endmodule

// File: rtl/deck_dealer_ctrl.sv
// deck_dealer_ctrl: shuffle sequencing, player/dealer draw arbitration and card decode for the shared deck
module deck_dealer_ctrl
  import blackjack_pkg::*;
#(
  parameter int DECK_SIZE = blackjack_pkg::DECK_SIZE,
  parameter int SHUF_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_round,
  input  logic       req_p,
  input  logic       req_d,
  input  logic       shuffle_ok,
  input  logic [7:0] mem_rd_data,
  output logic       mix_cards,
  output logic       mem_rd,
  output logic [5:0] mem_addr,
  output logic       gnt_p,
  output logic       gnt_d,
  output logic       card_valid,
  output logic [4:0] card_value,
  output logic       card_is_ace,
  output logic [5:0] cards_left,
  output logic       reshuffled,
  output logic       rank_err
);
  localparam logic [7:0] TMO = 8'(SHUF_TIMEOUT);
  localparam logic [5:0] LAST = 6'(DECK_SIZE - 1);
  localparam logic [5:0] FULL = 6'(DECK_SIZE);
  state_t state, state_n;
  logic armed, prio_d, nr_lat, gsel_p, any_req, busy, done_shuf;
  logic [5:0] ptr;
  logic [7:0] tmo;
  logic [4:0] dec_value;
  logic dec_ace, dec_err, unused_bits;
  card_decoder u_dec (
    .rank  (mem_rd_data[RANK_MSB:RANK_LSB]),
    .value (dec_value),
    .is_ace(dec_ace),
    .err   (dec_err)
  );
  assign unused_bits = ^{mem_rd_data[7:SUIT_MSB+1], mem_rd_data[SUIT_MSB:SUIT_LSB]};
  assign any_req = req_p || req_d;
  assign done_shuf = state == SHUF_WAIT && shuffle_ok;
  assign busy = state inside {READ, WAIT, DONE};
  // armed holds SHUF_REQ one idle cycle after reset so the reset cycle itself drives no pulse
  assign mix_cards = state == SHUF_REQ && armed;
  assign mem_rd = state == READ;
  assign mem_addr = ptr;
  assign gnt_p = busy && gsel_p;
  assign gnt_d = busy && !gsel_p;
  assign card_valid = state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      SHUF_REQ:  state_n = armed ? SHUF_WAIT : SHUF_REQ;
      SHUF_WAIT: state_n = shuffle_ok ? READY : tmo == TMO ? SHUF_REQ : SHUF_WAIT;
      READY:     state_n = (nr_lat || new_round || (any_req && cards_left == 6'd0)) ? SHUF_REQ
                         : any_req ? READ : READY;
      READ:      state_n = WAIT;
      WAIT:      state_n = DONE;
      DONE:      state_n = READY;
      default:   state_n = SHUF_REQ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= SHUF_REQ;
      armed <= 1'b0;
      ptr <= 6'd0;
      cards_left <= 6'd0;
      prio_d <= 1'b0;
      nr_lat <= 1'b0;
      tmo <= 8'd0;
      gsel_p <= 1'b0;
      card_value <= 5'd0;
      card_is_ace <= 1'b0;
      rank_err <= 1'b0;
      reshuffled <= 1'b0;
    end else begin
      state <= state_n;
      armed <= 1'b1;
      reshuffled <= done_shuf;
      nr_lat <= new_round || (nr_lat && !done_shuf);
      tmo <= state == SHUF_WAIT ? tmo + 8'd1 : 8'd0;
      if (done_shuf) begin
        ptr <= 6'd0;
        cards_left <= FULL;
        prio_d <= 1'b0;
      end
      if (state == READY) gsel_p <= req_p && (!req_d || !prio_d);
      if (state == WAIT) begin
        card_value <= dec_value;
        card_is_ace <= dec_ace;
        rank_err <= rank_err || dec_err;
      end
      if (state == DONE) begin
        ptr <= ptr == LAST ? 6'd0 : ptr + 6'd1;
        cards_left <= cards_left - 6'd1;
        prio_d <= gsel_p;
      end
    end
  end
endmodule

// File: tb/tb_deck_dealer_ctrl.sv
// tb_deck_dealer_ctrl: table-driven directed bench for the deck dealer controller
module tb_deck_dealer_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic new_round = 1'b0;
  logic req_p = 1'b0;
  logic req_d = 1'b0;
  logic shuffle_ok = 1'b0;
  logic [7:0] mem_rd_data = 8'd0;
  logic mix_cards, mem_rd, gnt_p, gnt_d, card_valid, card_is_ace, reshuffled, rank_err;
  logic [5:0] mem_addr, cards_left;
  logic [4:0] card_value;
  logic [7:0] deck [64];
  int checks = 0;
  int failures = 0;
  int excl_err = 0;
  typedef struct {
    logic [7:0] word;
    bit         is_p;
    logic [4:0] value;
    logic       ace;
  } vec_t;
  vec_t vecs [6];
  deck_dealer_ctrl dut (
    .clk(clk), .reset(reset), .new_round(new_round), .req_p(req_p), .req_d(req_d),
    .shuffle_ok(shuffle_ok), .mem_rd_data(mem_rd_data), .mix_cards(mix_cards),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .gnt_p(gnt_p), .gnt_d(gnt_d),
    .card_valid(card_valid), .card_value(card_value), .card_is_ace(card_is_ace),
    .cards_left(cards_left), .reshuffled(reshuffled), .rank_err(rank_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd) mem_rd_data <= deck[mem_addr];
  always @(negedge clk) if (gnt_p && gnt_d) excl_err <= excl_err + 1;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_mix"}, 32'(mix_cards), 0);
    chk({tag, "_mem_rd"}, 32'(mem_rd), 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_gnt"}, 32'({gnt_p, gnt_d}), 0);
    chk({tag, "_valid"}, 32'(card_valid), 0);
    chk({tag, "_value"}, 32'({card_is_ace, card_value}), 0);
    chk({tag, "_left"}, 32'(cards_left), 0);
    chk({tag, "_resh"}, 32'(reshuffled), 0);
    chk({tag, "_rank_err"}, 32'(rank_err), 0);
  endtask
  task automatic shuffle(input int dly);
    int n;
    n = 0;
    while (!mix_cards && n < 600) begin
      tick();
      n++;
    end
    chk("mix_pulse", 32'(mix_cards), 1);
    tick();
    chk("mix_one_cycle", 32'(mix_cards), 0);
    repeat (dly - 1) tick();
    shuffle_ok = 1'b1;
    tick();
    shuffle_ok = 1'b0;
    chk("reshuffled", 32'(reshuffled), 1);
    chk("cards_full", 32'(cards_left), 52);
  endtask
  task automatic draw(input bit rp, input bit rd, input bit exp_p, input logic [7:0] word,
                      input logic [4:0] ev, input logic ea, input logic [5:0] addr,
                      input logic [5:0] left, input bit keep);
    deck[addr] = word;
    req_p = rp;
    req_d = rd;
    tick();
    chk("read_strobe", 32'(mem_rd), 1);
    chk("read_addr", 32'(mem_addr), 32'(addr));
    chk("read_gnt", 32'({gnt_p, gnt_d}), 32'({exp_p, !exp_p}));
    tick();
    chk("wait_strobe", 32'({mem_rd, card_valid}), 0);
    chk("wait_gnt", 32'({gnt_p, gnt_d}), 32'({exp_p, !exp_p}));
    tick();
    chk("done_valid", 32'(card_valid), 1);
    chk("done_value", 32'(card_value), 32'(ev));
    chk("done_ace", 32'(card_is_ace), 32'(ea));
    chk("done_gnt", 32'({gnt_p, gnt_d}), 32'({exp_p, !exp_p}));
    if (!keep) begin
      req_p = 1'b0;
      req_d = 1'b0;
    end
    tick();
    chk("ready_gnt", 32'({gnt_p, gnt_d, card_valid}), 0);
    chk("ready_left", 32'(cards_left), 32'(left));
    chk("value_hold", 32'(card_value), 32'(ev));
  endtask
  initial begin
    int n;
    vecs[0] = '{8'h01, 1'b1, 5'd11, 1'b1};
    vecs[1] = '{8'h0C, 1'b1, 5'd10, 1'b0};
    vecs[2] = '{8'h07, 1'b1, 5'd7, 1'b0};
    vecs[3] = '{8'h1D, 1'b0, 5'd10, 1'b0};
    vecs[4] = '{8'h2A, 1'b0, 5'd10, 1'b0};
    vecs[5] = '{8'h32, 1'b1, 5'd2, 1'b0};
    for (int i = 0; i < 64; i++) deck[i] = 8'h02;
    repeat (3) tick();
    chk_zero("reset");
    reset = 1'b1;
    tick();
    shuffle(5);
    for (int i = 0; i < 6; i++)
      draw(vecs[i].is_p, !vecs[i].is_p, vecs[i].is_p, vecs[i].word, vecs[i].value, vecs[i].ace,
           6'(i), 6'(51 - i), 1'b0);
    chk("no_rank_err", 32'(rank_err), 0);
    deck[6] = 8'h05;
    req_p = 1'b1;
    tick();
    new_round = 1'b1;
    tick();
    new_round = 1'b0;
    tick();
    chk("nr_card_valid", 32'(card_valid), 1);
    chk("nr_card_value", 32'(card_value), 5);
    req_p = 1'b0;
    tick();
    chk("nr_left", 32'(cards_left), 45);
    req_p = 1'b1;
    tick();
    chk("nr_shuffle_first", 32'({mix_cards, gnt_p, gnt_d}), 32'(3'b100));
    shuffle(3);
    draw(1'b1, 1'b0, 1'b1, 8'h03, 5'd3, 1'b0, 6'd0, 6'd51, 1'b0);
    new_round = 1'b1;
    req_p = 1'b1;
    req_d = 1'b1;
    tick();
    chk("nr_beats_req", 32'({mix_cards, gnt_p, gnt_d, mem_rd}), 32'(4'b1000));
    new_round = 1'b0;
    req_p = 1'b0;
    req_d = 1'b0;
    shuffle(2);
    for (int i = 0; i < 4; i++)
      draw(1'b1, 1'b1, !i[0], 8'h08, 5'd8, 1'b0, 6'(i), 6'(51 - i), i != 3);
    for (int i = 4; i < 52; i++)
      draw(1'b1, 1'b0, 1'b1, 8'h02, 5'd2, 1'b0, 6'(i), 6'(51 - i), 1'b0);
    chk("ptr_wrap", 32'(mem_addr), 0);
    req_d = 1'b1;
    tick();
    chk("empty_reshuffle", 32'({mix_cards, gnt_p, gnt_d}), 32'(3'b100));
    shuffle(4);
    draw(1'b0, 1'b1, 1'b0, 8'h0B, 5'd10, 1'b0, 6'd0, 6'd51, 1'b0);
    draw(1'b1, 1'b0, 1'b1, 8'h0E, 5'd0, 1'b0, 6'd1, 6'd50, 1'b0);
    chk("rank_err_set", 32'(rank_err), 1);
    draw(1'b1, 1'b0, 1'b1, 8'h04, 5'd4, 1'b0, 6'd2, 6'd49, 1'b0);
    chk("rank_err_sticky", 32'(rank_err), 1);
    new_round = 1'b1;
    tick();
    new_round = 1'b0;
    chk("timeout_first_mix", 32'(mix_cards), 1);
    tick();
    n = 1;
    while (!mix_cards && n < 600) begin
      tick();
      n++;
    end
    chk("timeout_gap", 32'(n), 257);
    shuffle(3);
    deck[0] = 8'h09;
    req_p = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    req_p = 1'b0;
    tick();
    chk_zero("midreset");
    tick();
    chk("held_reset_mix", 32'(mix_cards), 0);
    reset = 1'b1;
    tick();
    chk("restart_mix", 32'(mix_cards), 1);
    chk("gnt_exclusive", 32'(excl_err), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
